cycle_sequencer: RTL

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

---
 rtl/cycle_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/cycle_sequencer.sv
// Per-line memory access sequencer. It steps through the sprite, refresh, fetch and idle
// cycle types once per phi half-cycle, as signalled by the phi_phase_start_1 strobe.
module cycle_sequencer #(
  parameter int unsigned NUM_SPRITES = 8,
  parameter int unsigned NUM_REFRESH = 5,
  parameter int unsigned RST_SPRITE  = 3
) (
  input  logic                   clk_dot4x,
  input  logic                   rst_n,
  input  logic                   clk_phi,
  input  logic                   phi_phase_start_1,
  input  logic [NUM_SPRITES-1:0] sprite_dma,
  input  logic                   badline,
  input  logic [6:0]             cycle_num,
  input  logic [6:0]             fetch_last,
  input  logic [2:0]             idle_pre,
  input  logic                   idle_post,
  input  logic                   restart,
  output logic [3:0]             cycle_type,
  output logic [2:0]             sprite_cnt,
  output logic [2:0]             refresh_cnt,
  output logic [2:0]             idle_cnt,
  output logic                   sprite_phase,
  output logic                   line_wrap
);

  // Codes 0..5 are low-phase cycles and 6..15 are high-phase cycles.
  typedef enum logic [3:0] {
    VicLp   = 4'd0,
    VicLpi2 = 4'd1,
    VicLs2  = 4'd2,
    VicLr   = 4'd3,
    VicLg   = 4'd4,
    VicLi   = 4'd5,
    VicHi   = 4'd6,
    VicHgi  = 4'd7,
    VicHs1  = 4'd8,
    VicHpi1 = 4'd9,
    VicHpi3 = 4'd10,
    VicHs3  = 4'd11,
    VicHri  = 4'd12,
    VicHrc  = 4'd13,
    VicHrx  = 4'd14,
    VicHgc  = 4'd15
  } cycle_e;

  localparam logic [2:0] LastSprite  = 3'(NUM_SPRITES - 1);
  localparam logic [2:0] LastRefresh = 3'(NUM_REFRESH - 1);
  localparam logic [2:0] RstSprite   = 3'(RST_SPRITE);

  cycle_e     state_q, state_d;
  logic [2:0] sprite_cnt_q, sprite_cnt_d;
  logic [2:0] refresh_cnt_q, refresh_cnt_d;
  logic [2:0] idle_cnt_q, idle_cnt_d;
  logic       post_pend_q, post_pend_d;
  logic       line_wrap_q, line_wrap_d;
  logic [7:0] dma_ext;

  // Widened so a 3-bit slot index is always in range for narrow builds.
  assign dma_ext = 8'(sprite_dma);

  always_comb begin
    state_d       = state_q;
    sprite_cnt_d  = sprite_cnt_q;
    refresh_cnt_d = refresh_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    post_pend_d   = post_pend_q;
    line_wrap_d   = 1'b0;

    if (phi_phase_start_1) begin
      if (restart) begin
        state_d     = VicHi;
        idle_cnt_d  = 3'd0;
        post_pend_d = 1'b0;
      end else if (clk_phi) begin
        case (state_q)
          VicLp:   state_d = dma_ext[sprite_cnt_q] ? VicHs1 : VicHpi1;
          VicLpi2: state_d = VicHpi3;
          VicLs2:  state_d = VicHs3;
          VicLr: begin
            if (refresh_cnt_q == LastRefresh) state_d = badline ? VicHrc : VicHrx;
            else                              state_d = VicHri;
          end
          VicLg: begin
            if (cycle_num == fetch_last) begin
              state_d    = VicHi;
              idle_cnt_d = 3'd0;
            end else begin
              state_d = badline ? VicHgc : VicHgi;
            end
          end
          VicLi:   state_d = VicHi;
          default: ;
        endcase
      end else begin
        case (state_q)
          VicHs1:  state_d = VicLs2;
          VicHpi1: state_d = VicLpi2;
          VicHri: begin
            state_d       = VicLr;
            refresh_cnt_d = refresh_cnt_q + 3'd1;
          end
          VicHrc, VicHrx, VicHgc, VicHgi: state_d = VicLg;
          VicHs3, VicHpi3: begin
            if (sprite_cnt_q == LastSprite) begin
              sprite_cnt_d  = 3'd0;
              refresh_cnt_d = 3'd0;
              line_wrap_d   = 1'b1;
              if (idle_post) begin
                state_d     = VicLi;
                post_pend_d = 1'b1;
              end else begin
                state_d = VicLr;
              end
            end else begin
              state_d      = VicLp;
              sprite_cnt_d = sprite_cnt_q + 3'd1;
            end
          end
          VicHi: begin
            if (post_pend_q) begin
              state_d     = VicLr;
              post_pend_d = 1'b0;
            end else if (idle_cnt_q == idle_pre) begin
              state_d = VicLp;
            end else begin
              state_d    = VicLi;
              idle_cnt_d = (idle_cnt_q == 3'd7) ? 3'd7 : idle_cnt_q + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_dot4x) begin
    if (!rst_n) begin
      state_q       <= VicLp;
      sprite_cnt_q  <= RstSprite;
      refresh_cnt_q <= 3'd0;
      idle_cnt_q    <= 3'd0;
      post_pend_q   <= 1'b0;
      line_wrap_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sprite_cnt_q  <= sprite_cnt_d;
      refresh_cnt_q <= refresh_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      post_pend_q   <= post_pend_d;
      line_wrap_q   <= line_wrap_d;
    end
  end

  assign cycle_type   = state_q;
  assign sprite_cnt   = sprite_cnt_q;
  assign refresh_cnt  = refresh_cnt_q;
  assign idle_cnt     = idle_cnt_q;
  assign line_wrap    = line_wrap_q;
  assign sprite_phase = (state_q == VicHs1) || (state_q == VicLs2) || (state_q == VicHs3);

endmodule
